// File: rtl/instruction_fetch_queue_pkg.sv
// Shared widths, constants and the queue entry layout for the instruction fetch queue.
package instruction_fetch_queue_pkg;

  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 64;

  localparam logic [ADDR_W-1:0] PC_INC           = 64'd4;
  localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 64'h0000_0000_0004_0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_fetch_queue_fifo.sv
// Synchronous FIFO with flush, occupancy count and a zero-cycle head read.
module fetch_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign head_data = empty ? '0 : mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // NOTE: storage has no reset; the empty mask on head_data keeps stale words off the outputs.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch_queue.sv
// Instruction fetch front end: issues in-order fetches, buffers responses for decode, flushes on redirect.
module instruction_fetch_queue
  import instruction_fetch_queue_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [ADDR_W-1:0]  imem_req_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic               dec_valid,
  input  logic               dec_ready,
  output logic [INSTR_W-1:0] dec_instr,
  output logic [ADDR_W-1:0]  dec_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = CW + 2;

  logic [ADDR_W-1:0] fetch_pc;
  logic [CW-1:0]     queue_count;
  logic [CW-1:0]     pending_count;
  logic [CW-1:0]     drop_count;
  logic [OW-1:0]     occupancy;
  logic              queue_empty;
  logic              queue_full;
  logic              pending_empty;
  logic              pending_full;
  logic              req_fire;
  logic              rsp_keep;
  logic              dec_fire;
  logic [ADDR_W-1:0] rsp_addr;
  fetch_entry_t      rsp_entry;
  fetch_entry_t      head_entry;

  // Stale requests still occupy memory-side slots, so they count against the bound.
  assign occupancy = OW'(queue_count) + OW'(pending_count) + OW'(drop_count);

  assign imem_req_valid = !rst && !redirect && !queue_full && !pending_full
                          && (occupancy < OW'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect && (drop_count == '0) && !pending_empty;
  assign dec_fire       = dec_valid && dec_ready;

  assign rsp_entry  = '{instr: imem_rsp_data, pc: rsp_addr};
  assign dec_valid  = !queue_empty;
  assign dec_instr  = head_entry.instr;
  assign dec_pc     = head_entry.pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= redirect_target;
    else if (req_fire) fetch_pc <= fetch_pc + PC_INC;
  end

  // A response in the redirect cycle retires either a stale or a pending request, hence the minus one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count <= '0;
    end else if (redirect) begin
      drop_count <= drop_count + pending_count + CW'(req_fire) - CW'(imem_rsp_valid);
    end else if (imem_rsp_valid && (drop_count != '0)) begin
      drop_count <= drop_count - 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(ADDR_W)
  ) u_pending_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (req_fire),
    .push_data (fetch_pc),
    .pop       (rsp_keep),
    .head_data (rsp_addr),
    .count     (pending_count),
    .empty     (pending_empty),
    .full      (pending_full)
  );

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(fetch_entry_t))
  ) u_instr_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (rsp_keep),
    .push_data (rsp_entry),
    .pop       (dec_fire),
    .head_data (head_entry),
    .count     (queue_count),
    .empty     (queue_empty),
    .full      (queue_full)
  );

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Self-checking bench: vector table, directed redirect/reset sequences and randomized traffic vs. a queue model.
module tb_instruction_fetch_queue;
  import instruction_fetch_queue_pkg::*;

  localparam int          DEPTH  = 4;
  localparam logic [63:0] RST_PC = 64'h0000_0000_0004_0000;

  logic        clk, rst, redirect, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        dec_valid, dec_ready;
  logic [63:0] redirect_target, imem_req_addr, dec_pc;
  logic [31:0] imem_rsp_data, dec_instr;

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .dec_valid       (dec_valid),
    .dec_ready       (dec_ready),
    .dec_instr       (dec_instr),
    .dec_pc          (dec_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model entry: requested address, cycle its response is due, and the fetch epoch it belongs to.
  typedef struct { logic [63:0] addr; int due; int epoch; } mem_req_t;

  typedef struct {
    logic        dec_ready;
    logic        exp_req_valid;
    logic [63:0] exp_req_addr;
    logic        exp_dec_valid;
    logic [63:0] exp_dec_pc;
  } vec_t;

  mem_req_t    mem_q[$];
  int          cyc, last_due, epoch, iq_count, lat_min, lat_max, dec_count, acc_count;
  bit          ready_random;
  logic [63:0] exp_req_addr, exp_dec_pc, last_dec_pc;
  int          n_checks, n_pass;

  function automatic logic [31:0] instr_of(logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9BDF;
  endfunction

  task automatic check(string name, logic [63:0] actual, logic [63:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, actual, expected, $time);
  endtask

  task automatic model_clear();
    mem_q.delete();
    iq_count     = 0;
    last_due     = -1;
    exp_req_addr = RST_PC;
    exp_dec_pc   = RST_PC;
    epoch++;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect = 1'b0; redirect_target = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; dec_ready = 1'b0;
    model_clear();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic drive_cycle();
    imem_req_ready = ready_random ? 1'($urandom_range(0, 1)) : 1'b1;
    if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
  endtask

  task automatic finish_cycle();
    bit       exp_rv, accepted;
    mem_req_t e;
    exp_rv   = (mem_q.size() + iq_count < DEPTH) && !redirect;
    accepted = imem_req_valid && imem_req_ready;
    check("req_valid", 64'(imem_req_valid), 64'(exp_rv));
    check("dec_valid", 64'(dec_valid), 64'(iq_count > 0));
    if (dec_valid && dec_ready) begin
      check("dec_pc", dec_pc, exp_dec_pc);
      check("dec_instr", 64'(dec_instr), 64'(instr_of(exp_dec_pc)));
      last_dec_pc = dec_pc;
      exp_dec_pc  = exp_dec_pc + 64'd4;
      if (iq_count > 0) iq_count--;
      dec_count++;
    end
    if (imem_rsp_valid) begin
      e = mem_q.pop_front();
      if (e.epoch == epoch && !redirect) iq_count++;
    end
    if (accepted) begin
      check("req_addr", imem_req_addr, exp_req_addr);
      e.addr  = imem_req_addr;
      e.epoch = epoch;
      e.due   = cyc + int'($urandom_range(lat_min, lat_max));
      if (e.due <= last_due) e.due = last_due + 1;
      last_due = e.due;
      mem_q.push_back(e);
      acc_count++;
    end
    if (redirect) begin
      iq_count     = 0;
      epoch++;
      exp_req_addr = redirect_target;
      exp_dec_pc   = redirect_target;
    end else if (accepted) begin
      exp_req_addr = exp_req_addr + 64'd4;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      drive_cycle();
      finish_cycle();
    end
  endtask

  vec_t vecs[6];
  bit   captured;
  logic [63:0] first_pc;

  initial begin
    n_checks = 0; n_pass = 0; epoch = 0; dec_count = 0; acc_count = 0;
    ready_random = 1'b0; lat_min = 1; lat_max = 1; last_dec_pc = '0;
    rst = 1'b1;

    vecs[0] = '{1'b1, 1'b1, 64'h40000, 1'b0, 64'h0};
    vecs[1] = '{1'b1, 1'b1, 64'h40004, 1'b0, 64'h0};
    vecs[2] = '{1'b1, 1'b1, 64'h40008, 1'b1, 64'h40000};
    vecs[3] = '{1'b1, 1'b1, 64'h4000c, 1'b1, 64'h40004};
    vecs[4] = '{1'b1, 1'b1, 64'h40010, 1'b1, 64'h40008};
    vecs[5] = '{1'b1, 1'b1, 64'h40014, 1'b1, 64'h4000c};

    // Reset values while rst is held.
    rst = 1'b1; redirect = 1'b0; redirect_target = '0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; dec_ready = 1'b0;
    model_clear();
    @(posedge clk); #1;
    check("rst_req_valid", 64'(imem_req_valid), 64'd0);
    check("rst_dec_valid", 64'(dec_valid), 64'd0);
    check("rst_dec_instr", 64'(dec_instr), 64'd0);
    check("rst_dec_pc", dec_pc, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; cyc = 0;

    // Steady-state streaming, latency 1, always ready.
    for (int i = 0; i < 6; i++) begin
      dec_ready = vecs[i].dec_ready;
      redirect  = 1'b0;
      drive_cycle();
      check("vec_req_valid", 64'(imem_req_valid), 64'(vecs[i].exp_req_valid));
      check("vec_req_addr", imem_req_addr, vecs[i].exp_req_addr);
      check("vec_dec_valid", 64'(dec_valid), 64'(vecs[i].exp_dec_valid));
      if (vecs[i].exp_dec_valid) check("vec_dec_pc", dec_pc, vecs[i].exp_dec_pc);
      finish_cycle();
    end
    run(10);

    // Decode stalled: exactly DEPTH requests, then issue stops with the queue full.
    do_reset();
    lat_min = 1; lat_max = 1; dec_ready = 1'b0; acc_count = 0;
    run(10);
    check("stall_issued", 64'(acc_count), 64'(DEPTH));
    drive_cycle();
    check("stall_req_valid", 64'(imem_req_valid), 64'd0);
    check("stall_dec_valid", 64'(dec_valid), 64'd1);
    finish_cycle();
    dec_ready = 1'b1; dec_count = 0;
    run(20);
    check("resume_decodes", 64'(dec_count >= 12), 64'd1);

    // Two requests in flight when redirect hits; both responses must be dropped.
    do_reset();
    lat_min = 3; lat_max = 3; dec_ready = 1'b1;
    run(2);
    redirect = 1'b1; redirect_target = 64'h1000;
    drive_cycle();
    finish_cycle();
    redirect = 1'b0; lat_min = 1; lat_max = 1;
    drive_cycle();
    check("redir_req_addr", imem_req_addr, 64'h1000);
    finish_cycle();
    dec_count = 0; captured = 1'b0; first_pc = '0;
    for (int i = 0; i < 15; i++) begin
      drive_cycle();
      finish_cycle();
      if (dec_count > 0 && !captured) begin captured = 1'b1; first_pc = last_dec_pc; end
    end
    check("redir_seen", 64'(captured), 64'd1);
    check("redir_first_pc", first_pc, 64'h1000);

    // Redirect together with a decode transfer and a response arrival.
    do_reset();
    lat_min = 1; lat_max = 1; dec_ready = 1'b1;
    run(6);
    redirect = 1'b1; redirect_target = 64'h2000_0000_0000_0100;
    drive_cycle();
    check("coinc_pre", 64'(dec_valid && imem_rsp_valid), 64'd1);
    finish_cycle();
    redirect = 1'b0;
    drive_cycle();
    check("coinc_cleared", 64'(dec_valid), 64'd0);
    finish_cycle();
    run(10);

    // Back-to-back redirects: the second target wins.
    lat_min = 3; lat_max = 3;
    run(4);
    redirect = 1'b1; redirect_target = 64'h0000_0000_0000_a000;
    run(1);
    redirect_target = 64'hffff_ffff_ffff_fff8;
    run(1);
    redirect = 1'b0; lat_min = 1; lat_max = 2;
    dec_count = 0; captured = 1'b0; first_pc = '0;
    for (int i = 0; i < 20; i++) begin
      drive_cycle();
      finish_cycle();
      if (dec_count > 0 && !captured) begin captured = 1'b1; first_pc = last_dec_pc; end
    end
    check("b2b_first_pc", first_pc, 64'hffff_ffff_ffff_fff8);
    check("b2b_wrapped", 64'(dec_count >= 4), 64'd1);

    // Randomized traffic: random ready, latency 1-5, random decode stalls and redirects.
    do_reset();
    ready_random = 1'b1; lat_min = 1; lat_max = 5; dec_count = 0;
    for (int i = 0; i < 3000; i++) begin
      dec_ready = ($urandom_range(0, 9) < 7);
      redirect  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 3) == 0) redirect_target = 64'hffff_ffff_ffff_fff0;
      else redirect_target = {32'($urandom), 32'($urandom)} & ~64'h3;
      drive_cycle();
      finish_cycle();
    end
    redirect = 1'b0;
    check("rand_progress", 64'(dec_count >= 300), 64'd1);

    // Asynchronous reset between edges mid-stream.
    dec_ready = 1'b1;
    run(5);
    drive_cycle();
    #1 rst = 1'b1;
    #1;
    check("async_req_valid", 64'(imem_req_valid), 64'd0);
    check("async_dec_valid", 64'(dec_valid), 64'd0);
    check("async_dec_pc", dec_pc, 64'd0);
    check("async_dec_instr", 64'(dec_instr), 64'd0);
    model_clear();
    imem_rsp_valid = 1'b0; ready_random = 1'b0; lat_min = 1; lat_max = 1;
    @(posedge clk); #1;
    rst = 1'b0; cyc = 0;
    drive_cycle();
    check("post_rst_req_valid", 64'(imem_req_valid), 64'd1);
    check("post_rst_req_addr", imem_req_addr, RST_PC);
    finish_cycle();
    run(10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_queue.md
INSTRUCTION_FETCH_QUEUE -- requirements
Module: instruction_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries (power of two, >=2).
REQ-002 Parameter RESET_PC, default 64'h0000_0000_0004_0000, first fetch address after reset.
REQ-003 clk  input  1  sole clock, rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 redirect  input  1  branch taken; flush and restart fetch.
REQ-006 redirect_target  input  64  new fetch address, valid when redirect=1.
REQ-007 imem_req_valid  output  1  fetch request valid.
REQ-008 imem_req_ready  input  1  instruction memory accepts request.
REQ-009 imem_req_addr  output  64  fetch address.
REQ-010 imem_rsp_valid  input  1  in-order response for oldest outstanding request.
REQ-011 imem_rsp_data  input  32  instruction word.
REQ-012 dec_valid  output  1  instruction available to decode.
REQ-013 dec_ready  input  1  decode accepts instruction.
REQ-014 dec_instr  output  32  head-of-queue instruction.
REQ-015 dec_pc  output  64  address of dec_instr.

Function
REQ-016 Request accepted when imem_req_valid & imem_req_ready; response consumed when imem_rsp_valid; decode transfer when dec_valid & dec_ready.
REQ-017 Internal fetch_pc drives imem_req_addr; +4 on each accepted request (64-bit, modulo 2^64).
REQ-018 imem_req_valid = 1 iff (queue count + outstanding count) < DEPTH and not redirect; no combinational path from imem_req_ready to imem_req_valid.
REQ-019 Memory latency >=1 cycle; responses arrive strictly in request order; one response per accepted request.
REQ-020 Each outstanding request records its address in a side FIFO; on response, {data, address} written at tail; occupancy increments.
REQ-021 dec_valid = queue non-empty; dec_instr/dec_pc driven from head entry; registered storage, zero-cycle read.
REQ-022 Head/tail pointers wrap modulo DEPTH; full = count==DEPTH, empty = count==0; push and pop same cycle leave count unchanged.
REQ-023 Minimum latency request-accept to dec_valid: 1 cycle after imem_rsp_valid (response registered into queue).
REQ-024 redirect=1: next edge clears queue (count=0, dec_valid=0), fetch_pc <= redirect_target, outstanding requests become stale.
REQ-025 Stale tracking: drop counter <= outstanding count at redirect (including a request accepted in the redirect cycle); responses while drop counter >0 are discarded and decrement it.
REQ-026 New requests allowed during draining; occupancy bound of REQ-018 counts stale requests.
REQ-027 redirect coincident with decode transfer: transfer completes for decode, queue still cleared.
REQ-028 redirect coincident with response: response discarded.
REQ-029 Back-to-back redirects: latest target wins; drop counter accumulates correctly.
REQ-030 Counters sized clog2(DEPTH)+1; never overflow/underflow under legal stimulus.

Reset
REQ-031 While rst=1: fetch_pc=RESET_PC, count=0, outstanding=0, drop=0, pointers=0, imem_req_valid=0, dec_valid=0, dec_instr=0, dec_pc=0.
REQ-032 Reset asserted mid-operation aborts all in-flight state immediately; responses after deassertion for pre-reset requests are outside contract.
REQ-033 First request (addr RESET_PC) issued in first cycle after rst deasserts.

Structure
REQ-034 Shared package: RESET_PC constant, instruction width 32, address width 64, PC increment 4.
REQ-035 One sub-module: fetch_fifo (parameterised-depth sync FIFO, push/pop/flush, count), instantiated for instruction queue and outstanding-address queue.

Verification
REQ-036 Reset, memory always ready, latency 1, dec_ready=1 -> dec_pc sequence 0x40000, 0x40004, 0x40008, one per cycle steady state.
REQ-037 dec_ready=0 for 10 cycles -> exactly DEPTH (4) requests issued, imem_req_valid=0 after, queue full; dec_ready=1 -> issue resumes, no loss/duplication.
REQ-038 Two outstanding requests, redirect to 0x1000 -> both responses dropped, next dec_pc=0x1000.
REQ-039 redirect same cycle as dec transfer and response arrival -> transferred instr delivered, response dropped, dec_valid=0 next cycle.
REQ-040 imem_req_ready random 50%, latency random 1-5 -> dec_pc strictly increments by 4, instr matches memory model.
REQ-041 rst pulse mid-stream (async, between edges) -> outputs reset immediately, first request after release addr 0x40000.
